// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares one external memory command port between NUM_REQ requesters and
// routes in-order read data back to its issuer. Define EXT_MEM_ARB_PRIORITY_EN for strict priority on requester 0.
module ext_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned AWIDTH          = 24,
    parameter int unsigned DWIDTH          = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*AWIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DWIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DWIDTH-1:0]         rsp_data_o,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic                      mem_we_o,
    output logic [AWIDTH-1:0]         mem_addr_o,
    output logic [DWIDTH-1:0]         mem_wdata_o,
    input  logic                      mem_rvalid_i,
    input  logic [DWIDTH-1:0]         mem_rdata_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNTW = PTRW + 1;
`ifdef EXT_MEM_ARB_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q [MAX_OUTSTANDING];
    logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                fifo_full_c;
    logic                pop_c;
    logic                push_c;
    logic                stage_free_c;
    logic                hs_c;
    logic [NUM_REQ-1:0]  elig_c;
    logic [NUM_REQ-1:0]  grant_c;
    logic [IDW-1:0]      gnt_id_c;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
        return IDW'((32'(base) + k) % NUM_REQ);
    endfunction

    // A full FIFO still admits a read in the cycle it pops, since the count stays unchanged.
    assign pop_c        = mem_rvalid_i && (count_q != '0);
    assign fifo_full_c  = (count_q == CNTW'(MAX_OUTSTANDING));
    assign stage_free_c = !mem_valid_q || mem_ready_i;
    assign elig_c       = req_valid_i & (req_we_i | {NUM_REQ{!fifo_full_c || pop_c}});

    // Grant search: optional fixed winner 0, then round-robin from rr_ptr.
    always_comb begin
        logic found;
        grant_c  = '0;
        gnt_id_c = '0;
        found    = 1'b0;
        if (stage_free_c) begin
            if (PRIO_EN && elig_c[0]) begin
                grant_c[0] = 1'b1;
                found      = 1'b1;
            end
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && elig_c[rr_idx(rr_ptr_q, k)] &&
                    !(PRIO_EN && (rr_idx(rr_ptr_q, k) == '0))) begin
                    grant_c[rr_idx(rr_ptr_q, k)] = 1'b1;
                    gnt_id_c                     = rr_idx(rr_ptr_q, k);
                    found                        = 1'b1;
                end
            end
        end
    end

    assign hs_c        = |grant_c;
    assign req_ready_o = grant_c & {NUM_REQ{rst_n_i}};

    // Command stage, round-robin pointer and FIFO push.
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rr_ptr_d    = rr_ptr_q;
        push_c      = 1'b0;
        if (hs_c) begin
            mem_valid_d = 1'b1;
            mem_we_d    = req_we_i[gnt_id_c];
            mem_addr_d  = req_addr_i[32'(gnt_id_c)*AWIDTH +: AWIDTH];
            mem_wdata_d = req_wdata_i[32'(gnt_id_c)*DWIDTH +: DWIDTH];
            push_c      = !req_we_i[gnt_id_c];
            if (!(PRIO_EN && (gnt_id_c == '0))) begin
                rr_ptr_d = rr_idx(gnt_id_c, 1);
            end
        end else if (mem_ready_i) begin
            mem_valid_d = 1'b0;
        end
    end

    // Read-ID FIFO bookkeeping, response routing and status.
    always_comb begin
        wr_ptr_d    = push_c ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
        count_d     = count_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        if (pop_c) begin
            rsp_valid_d[id_q[rd_ptr_q]] = 1'b1;
            rsp_data_d                  = mem_rdata_i;
        end
        err_d  = err_q || (mem_rvalid_i && (count_q == '0));
        busy_d = mem_valid_d || (count_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            if (push_c) begin
                id_q[wr_ptr_q] <= gnt_id_c;
            end
        end
    end

    assign mem_valid_o = mem_valid_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: single read, round-robin (or priority when
// EXT_MEM_ARB_PRIORITY_EN is defined), backpressure, FIFO full, spurious data and reset.
module tb_ext_mem_arbiter;

`ifdef EXT_MEM_ARB_PRIORITY_EN
    localparam int unsigned N = 3;
`else
    localparam int unsigned N = 2;
`endif
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            mem_valid;
    logic            mem_ready;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic            err;

    int unsigned n_checks;
    int unsigned n_fails;

    ext_mem_arbiter #(
        .NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read from requester 1
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 24'h000100, 16'h0);
        mem_ready = 1'b1;
        #1;
        check("sr_ready", 32'(req_ready), 2);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 24'h000100, 16'h0);
        #1;
        check("sr_mem_valid", 32'(mem_valid), 1);
        check("sr_mem_we", 32'(mem_we), 0);
        check("sr_mem_addr", 32'(mem_addr), 32'h100);
        @(negedge clk);
        #1;
        check("sr_mem_valid_1cyc", 32'(mem_valid), 0);
        check("sr_busy_outstanding", 32'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        #1;
        check("sr_rsp_early", 32'(rsp_valid), 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("sr_rsp_valid", 32'(rsp_valid), 2);
        check("sr_rsp_data", 32'(rsp_data), 32'hBEEF);
        check("sr_busy_idle", 32'(busy), 0);
        @(negedge clk);
        #1;
        check("sr_rsp_pulse", 32'(rsp_valid), 0);

`ifdef EXT_MEM_ARB_PRIORITY_EN
        // Requester 0 wins every cycle while valid
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 24'h10, 16'h1);
        set_req(1, 1'b1, 1'b1, 24'h20, 16'h2);
        set_req(2, 1'b1, 1'b1, 24'h30, 16'h3);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("prio_ready0", 32'(req_ready), 1);
        end
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 24'h10, 16'h1);
        #1;
        check("prio_rr_a", 32'(req_ready), 4);
        @(negedge clk);
        #1;
        check("prio_rr_b", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
`else
        // Round-robin between two continuous writers
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 24'h10, 16'h1111);
        set_req(1, 1'b1, 1'b1, 24'h20, 16'h2222);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 1 : 2);
            if (k > 0) begin
                check("rr_mem_valid", 32'(mem_valid), 1);
                check("rr_mem_addr", 32'(mem_addr), (k % 2 == 1) ? 32'h10 : 32'h20);
            end
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rr_last_addr", 32'(mem_addr), 32'h20);
        check("rr_last_wdata", 32'(mem_wdata), 32'h2222);
        @(negedge clk);
`endif
        #1;
        check("idle_mem_valid", 32'(mem_valid), 0);

        // Backpressure: stage holds while mem_ready is low
        @(negedge clk);
        mem_ready = 1'b0;
        set_req(0, 1'b1, 1'b1, 24'hA0, 16'h00A0);
        #1;
        check("bp_first_grant", 32'(req_ready), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_req(0, 1'b1, 1'b1, 24'hA1, 16'h00A1);
            #1;
            check("bp_ready_low", 32'(req_ready), 0);
            check("bp_hold_valid", 32'(mem_valid), 1);
            check("bp_hold_addr", 32'(mem_addr), 32'hA0);
            check("bp_hold_wdata", 32'(mem_wdata), 32'hA0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("bp_next_addr", 32'(mem_addr), 32'hA1);
        check("bp_next_valid", 32'(mem_valid), 1);
        @(negedge clk);

        // FIFO full: four reads outstanding, fifth stalls while a write proceeds
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_req(0, 1'b1, 1'b0, 24'(32'h300 + k), 16'h0);
            #1;
            check("ff_read_grant", 32'(req_ready), 1);
        end
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 24'h304, 16'h0);
        set_req(1, 1'b1, 1'b1, 24'h500, 16'h5555);
        #1;
        check("ff_write_passes", 32'(req_ready), 2);
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 24'h500, 16'h5555);
        #1;
        check("ff_read_stalled", 32'(req_ready), 0);
        check("ff_write_issued", 32'(mem_addr), 32'h500);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1111;
        #1;
        check("ff_grant_on_pop", 32'(req_ready), 1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        req_valid  = '0;
        #1;
        check("ff_rsp_valid", 32'(rsp_valid), 1);
        check("ff_rsp_data", 32'(rsp_data), 32'h1111);
        check("ff_fifth_addr", 32'(mem_addr), 32'h304);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = 16'(32'h2000 + k);
            @(negedge clk);
            mem_rvalid = 1'b0;
            #1;
            check("ff_drain_valid", 32'(rsp_valid), 1);
            check("ff_drain_data", 32'(rsp_data), 32'h2000 + k);
        end
        check("ff_busy_done", 32'(busy), 0);
        check("ff_err_clear", 32'(err), 0);

        // Spurious read data with an empty FIFO
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("sp_no_rsp", 32'(rsp_valid), 0);
        check("sp_err_set", 32'(err), 1);
        @(negedge clk);
        #1;
        check("sp_err_sticky", 32'(err), 1);

        // Reset with two reads outstanding
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 24'h400, 16'h0);
        #1;
        check("rs_grant_a", 32'(req_ready), 1);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 24'h401, 16'h0);
        #1;
        check("rs_grant_b", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rs_busy_before", 32'(busy), 1);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        req_we    = '0;
        #1;
        check("rs_mem_valid", 32'(mem_valid), 0);
        check("rs_mem_addr", 32'(mem_addr), 0);
        check("rs_ready", 32'(req_ready), 0);
        check("rs_busy", 32'(busy), 0);
        check("rs_err", 32'(err), 0);
        check("rs_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hCAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("rs_late_no_rsp", 32'(rsp_valid), 0);
        check("rs_late_err", 32'(err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
